core_decode_queue: RTL and testbench
====================================

// Module: core_decode_queue
// PURPOSE
//  Parametrised RV32 decode stage with elastic buffering between fetch and execute.
//  Buffers fetched instructions in a DEPTH-entry queue, then decodes the head into core_pkg types:
//    opcode_e, instr_format_e, rd_src_e, register indices and immediate.
//  The decoded result is held in a registered output slot. Valid/ready on both sides, plus a flush.
// PARAMETERS
//  DEPTH     4   queue entries; power of 2, >=2; total capacity = DEPTH+1 (queue + output slot)
//  PC_WIDTH  32  width of carried PC
// PORTS
//  i_clk        in   1         clock
//  i_rst_n      in   1         async active-low reset
//  i_flush      in   1         discard all buffered/held instructions
//  i_valid      in   1         fetch: instruction valid
//  o_ready      out  1         fetch: queue can accept
//  i_instr      in   32        fetch: raw instruction
//  i_pc         in   PC_WIDTH  fetch: instruction PC
//  o_valid      out  1         exec: output slot valid
//  i_ready      in   1         exec: consumer accepts output slot
//  o_pc         out  PC_WIDTH  PC of decoded instr
//  o_opcode     out  opcode_e  instr[6:2]
//  o_format     out  instr_format_e
//  o_rd_src     out  rd_src_e
//  o_rd/o_rs1/o_rs2 out reg_index_t  instr[11:7]/[19:15]/[24:20]
//  o_funct3     out  3         instr[14:12]
//  o_imm        out  32        decoded immediate
//  o_rd_we      out  1         writes rd (never for rd==0)
//  o_illegal    out  1         undecodable instruction
//  o_count      out  $clog2(DEPTH+2)  occupancy incl. output slot
// BEHAVIOUR
//  Reset: queue empty; o_valid=0; o_count=0; all decoded outputs 0; o_ready=1 after reset.
//  Handshakes: transfer on valid&&ready at the clock edge. o_ready = queue not full (comb, no dependence on i_valid).
//   o_valid held, output data stable until i_ready.
//  Output slot loads from queue head when empty or consumed the same cycle.
//  Latency: accept at edge N -> queue; earliest o_valid after edge N+1.
//   Simultaneous push/pop on a full queue is not allowed: o_ready stays 0 while full.
//  Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
//  Flush: at next edge queue empty, o_valid=0, o_count=0. Concurrent input transfer is dropped.
//   Flush has priority over every other event.
//  Decode (comb on head, registered into slot):
//   instr[1:0]!=2'b11 -> illegal, format OTHER, rd_we=0, imm=0.
//   OP->R; OP_IMM/LOAD/JALR/MISC_MEM->I; STORE->S; BRANCH->B; LUI/AUIPC->U; JAL->J.
//   SYSTEM: funct3[2]=1 -> UIMM, else I.
//   Any other opcode -> OTHER, illegal=1.
//   rd_src: JAL/JALR->NEXT_SEQ_PC; LOAD->MEM_LOAD; SYSTEM->CSR; else ALU_RESULT.
//   rd_we=0 for STORE/BRANCH/MISC_MEM/illegal or rd==0; else 1.
//   imm I: sext(i[31:20]); S: sext({i[31:25],i[11:7]}); B: sext({i[31],i[7],i[30:25],i[11:8],1'b0}).
//   imm U: {i[31:12],12'b0}; J: sext({i[31],i[19:12],i[20],i[30:21],1'b0}).
//   imm UIMM: zext(i[19:15]); R/OTHER: 0.
//  Async reset mid-operation: everything returns to reset values immediately; in-flight instructions are lost.
// CONFIGURATION
//  CORE_DECODE_QUEUE_BYPASS_EN
//   Defined: if queue empty and output slot empty/consumed, the accepted input loads the slot directly at edge N.
//    Latency is 1 cycle. FIFO order is preserved: bypass only applies when the queue is empty.
//   Undefined: every instruction passes through the queue (latency 2).
// TESTING
//  ADDI 0xFFF00093, i_ready=1 -> format I, rd=1, rs1=0, imm=0xFFFFFFFF, rd_src ALU, rd_we=1.
//   o_valid 2 cycles after accept, or 1 with BYPASS_EN.
//  JAL 0x008000EF, SW 0x0020A223 -> J, imm=8, rd_src NEXT_SEQ_PC, rd_we=1.
//   Then S, rs1=1, rs2=2, imm=4, rd_we=0.
//  Instrs 0x00000000 and 0x0000007B -> both illegal=1, format OTHER, rd_we=0.
//  DEPTH=4, i_ready=0, push 7 -> 5 accepted, o_ready=0, o_count=5.
//   Then i_ready=1: 5 drain in order, one per cycle.
//  Full queue, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_count=0, o_ready=1.
//   The concurrent instruction does not appear.
//  Assert i_rst_n=0 mid-drain -> o_valid=0 and o_count=0 immediately.
//   After release, a new push decodes correctly.

Source files
------------

// File: rtl/core_decode_queue.sv
// RV32 decode stage: DEPTH-entry elastic queue between fetch and execute,
// with the queue head decoded into a registered output slot.
// Optional build macro: CORE_DECODE_QUEUE_BYPASS_EN lets an instruction skip
// the empty queue and load the output slot directly (1-cycle latency).

package core_pkg;

  typedef enum logic [4:0] {
    OPC_LOAD     = 5'b00000,
    OPC_MISC_MEM = 5'b00011,
    OPC_OP_IMM   = 5'b00100,
    OPC_AUIPC    = 5'b00101,
    OPC_STORE    = 5'b01000,
    OPC_OP       = 5'b01100,
    OPC_LUI      = 5'b01101,
    OPC_BRANCH   = 5'b11000,
    OPC_JALR     = 5'b11001,
    OPC_JAL      = 5'b11011,
    OPC_SYSTEM   = 5'b11100
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_OTHER = 3'd0,
    FMT_R     = 3'd1,
    FMT_I     = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6,
    FMT_UIMM  = 3'd7
  } instr_format_e;

  typedef enum logic [1:0] {
    RD_SRC_ALU_RESULT  = 2'd0,
    RD_SRC_MEM_LOAD    = 2'd1,
    RD_SRC_NEXT_SEQ_PC = 2'd2,
    RD_SRC_CSR         = 2'd3
  } rd_src_e;

  typedef logic [4:0] reg_index_t;

  typedef struct packed {
    opcode_e       opcode;
    instr_format_e format;
    rd_src_e       rd_src;
    reg_index_t    rd;
    reg_index_t    rs1;
    reg_index_t    rs2;
    logic [2:0]    funct3;
    logic [31:0]   imm;
    logic          rd_we;
    logic          illegal;
  } decoded_t;

endpackage

module core_decode_queue
  import core_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [31:0]                  i_instr,
  input  logic [PC_WIDTH-1:0]          i_pc,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [PC_WIDTH-1:0]          o_pc,
  output opcode_e                      o_opcode,
  output instr_format_e                o_format,
  output rd_src_e                      o_rd_src,
  output reg_index_t                   o_rd,
  output reg_index_t                   o_rs1,
  output reg_index_t                   o_rs2,
  output logic [2:0]                   o_funct3,
  output logic [31:0]                  o_imm,
  output logic                         o_rd_we,
  output logic                         o_illegal,
  output logic [$clog2(DEPTH+2)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 2);

  logic [31:0]         mem_instr [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc    [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  decoded_t            slot_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                valid_q;
  logic [CW-1:0]       count_q;

  logic [PW-1:0]       q_count, q_count_n;
  logic                q_empty, q_full;
  logic                push, slot_free, bypass, q_push, q_pop, load, valid_n;
  logic [31:0]         src_instr;
  logic [PC_WIDTH-1:0] src_pc;
  logic [CW-1:0]       count_n;
  decoded_t            dec;

  // Pure instruction decode into the packed payload
  function automatic decoded_t decode(input logic [31:0] in);
    decoded_t d;
    d         = '0;
    d.opcode  = opcode_e'(in[6:2]);
    d.rd      = in[11:7];
    d.rs1     = in[19:15];
    d.rs2     = in[24:20];
    d.funct3  = in[14:12];
    d.format  = FMT_OTHER;
    d.rd_src  = RD_SRC_ALU_RESULT;
    d.illegal = 1'b1;
    if (in[1:0] == 2'b11) begin
      d.illegal = 1'b0;
      case (d.opcode)
        OPC_OP:                                           d.format = FMT_R;
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM:     d.format = FMT_I;
        OPC_STORE:                                        d.format = FMT_S;
        OPC_BRANCH:                                       d.format = FMT_B;
        OPC_LUI, OPC_AUIPC:                               d.format = FMT_U;
        OPC_JAL:                                          d.format = FMT_J;
        OPC_SYSTEM:  d.format = in[14] ? FMT_UIMM : FMT_I;
        default:     d.illegal = 1'b1;
      endcase
      case (d.opcode)
        OPC_JAL, OPC_JALR: d.rd_src = RD_SRC_NEXT_SEQ_PC;
        OPC_LOAD:          d.rd_src = RD_SRC_MEM_LOAD;
        OPC_SYSTEM:        d.rd_src = RD_SRC_CSR;
        default:           d.rd_src = RD_SRC_ALU_RESULT;
      endcase
    end
    case (d.format)
      FMT_I:    d.imm = {{20{in[31]}}, in[31:20]};
      FMT_S:    d.imm = {{20{in[31]}}, in[31:25], in[11:7]};
      FMT_B:    d.imm = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      FMT_U:    d.imm = {in[31:12], 12'b0};
      FMT_J:    d.imm = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      FMT_UIMM: d.imm = {27'b0, in[19:15]};
      default:  d.imm = '0;
    endcase
    d.rd_we = !d.illegal && (d.rd != 5'd0) &&
              (d.opcode != OPC_STORE) && (d.opcode != OPC_BRANCH) &&
              (d.opcode != OPC_MISC_MEM);
    return d;
  endfunction

  // Queue status from wrap-bit pointers
  always_comb begin
    q_count = PW'(wr_ptr - rd_ptr);
    q_empty = (wr_ptr == rd_ptr);
    q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  end

  // Handshake resolution, slot load source and next occupancy
  always_comb begin
    push      = i_valid && !q_full;
    slot_free = !valid_q || i_ready;
`ifdef CORE_DECODE_QUEUE_BYPASS_EN
    bypass    = push && q_empty && slot_free;
`else
    bypass    = 1'b0;
`endif
    q_push    = push && !bypass;
    q_pop     = slot_free && !q_empty;
    load      = q_pop || bypass;
    src_instr = q_empty ? i_instr : mem_instr[rd_ptr[AW-1:0]];
    src_pc    = q_empty ? i_pc    : mem_pc[rd_ptr[AW-1:0]];
    dec       = decode(src_instr);
    valid_n   = load ? 1'b1 : (slot_free ? 1'b0 : valid_q);
    q_count_n = PW'(q_count + PW'(q_push) - PW'(q_pop));
    count_n   = CW'(q_count_n) + CW'(valid_n);
  end

  assign o_ready = !q_full;

  // Queue storage (payload only, no reset needed)
  always_ff @(posedge i_clk) begin
    if (q_push && !i_flush) begin
      mem_instr[wr_ptr[AW-1:0]] <= i_instr;
      mem_pc[wr_ptr[AW-1:0]]    <= i_pc;
    end
  end

  // Pointers, output slot and occupancy; flush overrides everything
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      slot_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      if (q_push) wr_ptr <= wr_ptr + PW'(1);
      if (q_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (load) begin
        slot_q <= dec;
        pc_q   <= src_pc;
      end
      valid_q <= valid_n;
      count_q <= count_n;
    end
  end

  assign o_valid   = valid_q;
  assign o_pc      = pc_q;
  assign o_opcode  = slot_q.opcode;
  assign o_format  = slot_q.format;
  assign o_rd_src  = slot_q.rd_src;
  assign o_rd      = slot_q.rd;
  assign o_rs1     = slot_q.rs1;
  assign o_rs2     = slot_q.rs2;
  assign o_funct3  = slot_q.funct3;
  assign o_imm     = slot_q.imm;
  assign o_rd_we   = slot_q.rd_we;
  assign o_illegal = slot_q.illegal;
  assign o_count   = count_q;

endmodule

// File: tb/tb_core_decode_queue.sv
// Scoreboard bench for core_decode_queue: accepted fetches are queued with their
// accept edge; a negedge monitor checks occupancy/ready/valid every cycle and
// compares every consumed output against a reference decode of the instruction.
module tb_core_decode_queue;
  import core_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PCW   = 32;
`ifdef CORE_DECODE_QUEUE_BYPASS_EN
  localparam int EXTRA_LAT = 0;
`else
  localparam int EXTRA_LAT = 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n, flush, valid, rdy;
  logic [31:0]         instr;
  logic [PCW-1:0]      pc;
  logic                o_ready, o_valid, o_rd_we, o_illegal;
  logic [PCW-1:0]      o_pc;
  opcode_e             o_opcode;
  instr_format_e       o_format;
  rd_src_e             o_rd_src;
  reg_index_t          o_rd, o_rs1, o_rs2;
  logic [2:0]          o_funct3;
  logic [31:0]         o_imm;
  logic [$clog2(DEPTH+2)-1:0] o_count;

  core_decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_valid(valid), .o_ready(o_ready), .i_instr(instr), .i_pc(pc),
    .o_valid(o_valid), .i_ready(rdy), .o_pc(o_pc), .o_opcode(o_opcode),
    .o_format(o_format), .o_rd_src(o_rd_src), .o_rd(o_rd), .o_rs1(o_rs1),
    .o_rs2(o_rs2), .o_funct3(o_funct3), .o_imm(o_imm), .o_rd_we(o_rd_we),
    .o_illegal(o_illegal), .o_count(o_count)
  );

  typedef struct { logic [31:0] instr; logic [31:0] pc; int acc; } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    edge_cnt = 0;
  int    last_pop = 0;
  logic [31:0] pc_ctr = 32'h1000;
  logic [4:0]  op_pool [12] = '{5'h0C, 5'h04, 5'h00, 5'h19, 5'h03, 5'h08,
                                5'h18, 5'h0D, 5'h05, 5'h1B, 5'h1C, 5'h1E};

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return v[bits-1] ? (v | ~((32'd1 << bits) - 32'd1)) : v;
  endfunction

  // Reference decode written from the instruction-set rules
  function automatic void model(input logic [31:0] x, output instr_format_e fmt,
                                output rd_src_e src, output logic [31:0] imm,
                                output logic we, output logic ill);
    logic [4:0] op;
    op  = x[6:2];
    fmt = FMT_OTHER;
    src = RD_SRC_ALU_RESULT;
    if (x[1:0] == 2'b11) begin
      case (op)
        5'h0C:                      fmt = FMT_R;
        5'h04, 5'h00, 5'h19, 5'h03: fmt = FMT_I;
        5'h08:                      fmt = FMT_S;
        5'h18:                      fmt = FMT_B;
        5'h0D, 5'h05:               fmt = FMT_U;
        5'h1B:                      fmt = FMT_J;
        5'h1C:                      fmt = x[14] ? FMT_UIMM : FMT_I;
        default:                    fmt = FMT_OTHER;
      endcase
      if (op == 5'h1B || op == 5'h19) src = RD_SRC_NEXT_SEQ_PC;
      else if (op == 5'h00)           src = RD_SRC_MEM_LOAD;
      else if (op == 5'h1C)           src = RD_SRC_CSR;
    end
    ill = (fmt == FMT_OTHER);
    case (fmt)
      FMT_I:    imm = sext(x >> 20, 12);
      FMT_S:    imm = sext(((x >> 25) << 5) | ((x >> 7) & 32'd31), 12);
      FMT_B:    imm = sext((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
                           (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1), 13);
      FMT_U:    imm = x & 32'hFFFF_F000;
      FMT_J:    imm = sext((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) |
                           (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1), 21);
      FMT_UIMM: imm = (x >> 15) & 32'd31;
      default:  imm = 32'd0;
    endcase
    we = !ill && (x[11:7] != 5'd0) && (op != 5'h08) && (op != 5'h18) && (op != 5'h03);
  endfunction

  // Output monitor and scoreboard bookkeeping, sampled mid-cycle
  item_t         it;
  int            occ;
  int            ready_at;
  logic          exp_v;
  instr_format_e e_fmt;
  rd_src_e       e_src;
  logic [31:0]   e_imm;
  logic          e_we, e_ill;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      check("reset_valid", 64'(o_valid), 64'(0));
      check("reset_count", 64'(o_count), 64'(0));
    end else begin
      occ   = sb.size();
      exp_v = 1'b0;
      if (occ > 0) begin
        ready_at = sb[0].acc + EXTRA_LAT;
        if (last_pop > ready_at) ready_at = last_pop;
        exp_v = (edge_cnt >= ready_at);
      end
      check("count", 64'(o_count), 64'(occ));
      check("ready", 64'(o_ready), 64'(occ < int'(DEPTH) + 1));
      check("valid", 64'(o_valid), 64'(exp_v));
      if (flush) begin
        sb.delete();
      end else begin
        if (o_valid && rdy) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 64'(1), 64'(0));
          end else begin
            it = sb.pop_front();
            model(it.instr, e_fmt, e_src, e_imm, e_we, e_ill);
            check("pc",      64'(o_pc),      64'(it.pc));
            check("opcode",  64'(o_opcode),  64'(it.instr[6:2]));
            check("format",  64'(o_format),  64'(e_fmt));
            check("rd_src",  64'(o_rd_src),  64'(e_src));
            check("rd",      64'(o_rd),      64'(it.instr[11:7]));
            check("rs1",     64'(o_rs1),     64'(it.instr[19:15]));
            check("rs2",     64'(o_rs2),     64'(it.instr[24:20]));
            check("funct3",  64'(o_funct3),  64'(it.instr[14:12]));
            check("imm",     64'(o_imm),     64'(e_imm));
            check("rd_we",   64'(o_rd_we),   64'(e_we));
            check("illegal", 64'(o_illegal), 64'(e_ill));
            last_pop = edge_cnt + 1;
          end
        end
        if (valid && o_ready) sb.push_back('{instr, pc, edge_cnt + 1});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] x);
    valid  = 1'b1;
    instr  = x;
    pc     = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    step();
  endtask

  task automatic drain();
    valid = 1'b0;
    rdy   = 1'b1;
    for (int i = 0; i < 100 && o_count != '0; i++) step();
    check("drain_done", 64'(o_count), 64'(0));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    r[6:2] = op_pool[$urandom_range(0, 11)];
    if ($urandom_range(0, 9) != 0) r[1:0] = 2'b11;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rdy = 1'b0;
    instr = '0; pc = '0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    check("init_valid",   64'(o_valid),   64'(0));
    check("init_count",   64'(o_count),   64'(0));
    check("init_ready",   64'(o_ready),   64'(1));
    check("init_imm",     64'(o_imm),     64'(0));
    check("init_pc",      64'(o_pc),      64'(0));
    check("init_format",  64'(o_format),  64'(0));
    check("init_rd_we",   64'(o_rd_we),   64'(0));
    check("init_illegal", 64'(o_illegal), 64'(0));
    step();

    // Directed decodes
    rdy = 1'b1;
    send(32'hFFF0_0093);
    valid = 1'b0;
    repeat (4) step();
    send(32'h0080_00EF);
    send(32'h0020_A223);
    send(32'h0000_0000);
    send(32'h0000_007B);
    drain();

    // Fill with consumer stalled: DEPTH+1 accepted, then ordered drain
    rdy = 1'b0;
    for (int i = 0; i < 7; i++) send(32'h0000_0093 | (32'(i + 1) << 7));
    valid = 1'b0;
    check("full_count", 64'(o_count), 64'(DEPTH + 1));
    check("full_ready", 64'(o_ready), 64'(0));
    drain();

    // Flush a full queue while an input is offered
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) send(32'h0010_0113);
    flush = 1'b1;
    send(32'h0050_0293);
    flush = 1'b0;
    valid = 1'b0;
    #1;
    check("flush_valid", 64'(o_valid), 64'(0));
    check("flush_count", 64'(o_count), 64'(0));
    check("flush_ready", 64'(o_ready), 64'(1));
    step();

    // Randomized traffic with occasional flush
    for (int i = 0; i < 600; i++) begin
      rdy   = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) < 6) send(rand_instr());
      else begin
        valid = 1'b0;
        step();
      end
    end
    flush = 1'b0;
    drain();

    // Asynchronous reset in the middle of a drain
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) send(rand_instr());
    valid = 1'b0;
    rdy   = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(o_valid), 64'(0));
    check("async_rst_count", 64'(o_count), 64'(0));
    repeat (2) step();
    rst_n = 1'b1;
    step();
    send(32'hFFF0_0093);
    drain();
    repeat (3) step();
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
